sqrt_round_pack: RTL and testbench
==================================

Name: sqrt_round_pack

Overview:
- Downstream stage of the LAMP FPU square-root datapath.
- Captures the raw root produced by the square-root core.
- Normalizes it and rounds to nearest-even, then packs sign, exponent and fraction into a LAMP float.
- Holds the packed result behind a valid/ready handshake.
- Special-case results (NaN, inf, zero, negative operand) come precomputed from the upstream unpack stage and bypass the core path.

Parameters:
- F_DW, 7, fraction width without hidden bit (LAMP_FLOAT_F_DW).
- E_DW, 8, biased exponent width (LAMP_FLOAT_E_DW).
- DW, 1+E_DW+F_DW = 16, packed float width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- start_i  in  1  upstream launches an operation; asserted in the same cycle as the core's doSqrt_i.
- special_i  in  1  qualified by start_i; the result is special_res_i and the core is not awaited.
- special_res_i  in  DW  precomputed packed special result.
- exp_res_i  in  E_DW  biased result exponent, already halved upstream; qualified by start_i.
- core_valid_i  in  1  square-root core result valid.
- core_res_i  in  2*(1+F_DW)  core root, unsigned fixed point, MSB = integer bit.
- ready_i  in  1  downstream accepts result_o.
- busy_o  out  1  block not in IDLE; upstream must not assert start_i.
- valid_o  out  1  result_o valid.
- result_o  out  DW  packed result.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; valid_o=0, busy_o=0, result_o=0; all capture registers cleared.
  - Reset takes effect from any state and aborts any operation in flight.
  - A core_valid_i arriving after reset is ignored.
- FSM states: IDLE, WAIT_CORE, ROUND, HOLD.
- IDLE:
  - start_i & special_i: register special_res_i into result_o, go to HOLD.
  - start_i & !special_i: capture exp_res_i, go to WAIT_CORE.
  - Otherwise stay in IDLE.
- WAIT_CORE:
  - core_valid_i: capture core_res_i, go to ROUND.
  - Otherwise wait indefinitely.
- ROUND: one cycle of arithmetic, register result_o, go to HOLD.
- HOLD:
  - valid_o=1; result_o is stable.
  - ready_i: go to IDLE. valid_o falls in the next cycle.
- Ignored inputs:
  - start_i outside IDLE is ignored.
  - core_valid_i outside WAIT_CORE is ignored.
- Latency:
  - Special: start_i at cycle N gives valid_o at N+1.
  - Normal: core_valid_i at cycle N gives valid_o at N+2.
  - No back-to-back overlap: at least one IDLE cycle between operations.
- Arithmetic (16-bit core_res r):
  - Normalization:
    - If r[15]=1, m=r.
    - Else if r[14]=1, m=r<<1 and the exponent is decremented by 1.
    - r<2^14 is illegal from the core. Pass m=r<<1 through; no assertion is required in RTL.
  - Fraction f=m[14:8], guard G=m[7], sticky S=|m[6:0].
  - Rounding is RNE: increment f when G & (S | f[0]).
  - If the increment carries out of f: f=0 and exponent+1.
  - Exponent arithmetic is E_DW bits. The upstream range [63,190] guarantees no overflow.
  - Packing: result_o = {1'b0, exp, f}. The sign is always 0 on the normal path.

Optional Feature:
- Macro: LAMP_SQRT_INEXACT_EN.
- Defined:
  - Adds output inexact_o (1 bit), valid with valid_o.
  - inexact_o = G|S of the rounded result; it is 0 for the special path.
  - inexact_o resets to 0 and is held through HOLD.
- Undefined: the port is absent and no G|S register is built.

Test Plan:
- sqrt(4.0):
  - Stimulus: start_i with exp_res_i=128, then core_res_i=0x8000.
  - Response: result_o=0x4000 two cycles after core_valid_i; inexact_o=0.
- sqrt(2.0):
  - Stimulus: exp_res_i=127, core_res_i=0xB505.
  - Response: result_o=0x3FB5 with G=0, S=1, so no round-up; inexact_o=1.
- Round carry:
  - Stimulus: exp_res_i=127, core_res_i=0xFF80.
  - Response: result_o=0x4000 (fraction wraps to 0, exponent becomes 128).
- Tie to even:
  - Stimulus: exp_res_i=127, core_res_i=0x8080.
  - Response: result_o=0x3F80 (no increment); inexact_o=1.
- Special bypass plus backpressure:
  - Stimulus: start_i & special_i with special_res_i=0x7FC0, and ready_i held low for 5 cycles.
  - Response: valid_o=1 from the next cycle with result_o=0x7FC0 stable for all 5 cycles and busy_o=1; one cycle after ready_i=1, valid_o=0.
- Reset mid-op:
  - Stimulus: rst=0 during WAIT_CORE, then core_valid_i pulses after reset is released.
  - Response: state=IDLE, valid_o stays 0, busy_o=0, and the late core_valid_i is ignored.

Source files
------------

// File: rtl/sqrt_round_pack.sv
// Square-root back end: normalizes the core root, rounds to nearest-even and packs a LAMP float.
// Optional macro LAMP_SQRT_INEXACT_EN adds an inexact_o flag alongside the result.
module sqrt_round_pack #(
  parameter int unsigned F_DW = 7,
  parameter int unsigned E_DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  special_i,
  input  logic [E_DW+F_DW:0]    special_res_i,
  input  logic [E_DW-1:0]       exp_res_i,
  input  logic                  core_valid_i,
  input  logic [2*(1+F_DW)-1:0] core_res_i,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [E_DW+F_DW:0]    result_o
`ifdef LAMP_SQRT_INEXACT_EN
  ,
  output logic                  inexact_o
`endif
);

  localparam int unsigned DW = 1 + E_DW + F_DW;
  localparam int unsigned CW = 2 * (1 + F_DW);
  localparam int unsigned SW = CW - 2 - F_DW;

  typedef enum logic [1:0] {IDLE, WAIT_CORE, ROUND, HOLD} state_t;

  state_t          state, state_next;
  logic [E_DW-1:0] exp_q;
  logic [CW-1:0]   core_q;

  logic [CW-2:0]   mant;
  logic [E_DW-1:0] exp_norm, exp_fin;
  logic [F_DW-1:0] frac;
  logic [F_DW:0]   frac_sum;
  logic            guard, sticky, inc;
  logic [DW-1:0]   packed_res;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start_i) state_next = special_i ? HOLD : WAIT_CORE;
      WAIT_CORE: if (core_valid_i) state_next = ROUND;
      ROUND:     state_next = HOLD;
      HOLD:      if (ready_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Normalize (drop the leading one), then round to nearest-even with carry into the exponent
  always_comb begin
    mant       = '0;
    exp_norm   = exp_q;
    exp_fin    = exp_q;
    frac       = '0;
    frac_sum   = '0;
    guard      = 1'b0;
    sticky     = 1'b0;
    inc        = 1'b0;
    packed_res = '0;
    if (core_q[CW-1]) begin
      mant = core_q[CW-2:0];
    end else begin
      mant     = {core_q[CW-3:0], 1'b0};
      exp_norm = exp_q - E_DW'(1);
    end
    frac     = mant[CW-2 -: F_DW];
    guard    = mant[SW];
    sticky   = |mant[SW-1:0];
    inc      = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + (F_DW+1)'(inc);
    exp_fin  = frac_sum[F_DW] ? exp_norm + E_DW'(1) : exp_norm;
    packed_res = {1'b0, exp_fin, frac_sum[F_DW-1:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Capture registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q     <= '0;
      core_q    <= '0;
      result_o  <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
`ifdef LAMP_SQRT_INEXACT_EN
      inexact_o <= 1'b0;
`endif
    end else begin
      valid_o <= (state_next == HOLD);
      busy_o  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start_i && special_i) begin
            result_o  <= special_res_i;
`ifdef LAMP_SQRT_INEXACT_EN
            inexact_o <= 1'b0;
`endif
          end else if (start_i) begin
            exp_q <= exp_res_i;
          end
        end
        WAIT_CORE: if (core_valid_i) core_q <= core_res_i;
        ROUND: begin
          result_o  <= packed_res;
`ifdef LAMP_SQRT_INEXACT_EN
          inexact_o <= guard | sticky;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_round_pack.sv
// Directed bench for sqrt_round_pack; honours LAMP_SQRT_INEXACT_EN when defined.
module tb_sqrt_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, special_i, core_valid_i, ready_i;
  logic [15:0] special_res_i, core_res_i;
  logic [7:0]  exp_res_i;
  logic        busy_o, valid_o;
  logic [15:0] result_o;
`ifdef LAMP_SQRT_INEXACT_EN
  logic        inexact_o;
`endif

  int total = 0;
  int bad   = 0;

  sqrt_round_pack dut (
    .clk(clk), .rst(rst), .start_i(start_i), .special_i(special_i),
    .special_res_i(special_res_i), .exp_res_i(exp_res_i),
    .core_valid_i(core_valid_i), .core_res_i(core_res_i), .ready_i(ready_i),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
`ifdef LAMP_SQRT_INEXACT_EN
    , .inexact_o(inexact_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_inexact(input string tag, input logic exp);
`ifdef LAMP_SQRT_INEXACT_EN
    chk(tag, 32'(inexact_o), 32'(exp));
`else
    if (exp === 1'bx) $display("unreachable");
`endif
  endtask

  // One normal operation: start, idle wait, core result, then one-cycle ready
  task automatic run_norm(input string tag, input logic [7:0] e, input logic [15:0] r,
                          input logic [15:0] exp_res, input logic exp_inex);
    start_i = 1'b1; special_i = 1'b0; exp_res_i = e;
    tick();
    start_i = 1'b0; exp_res_i = 8'h00;
    chk({tag, "_busy_wait"}, 32'(busy_o), 32'd1);
    tick(); tick();
    chk({tag, "_valid_wait"}, 32'(valid_o), 32'd0);
    core_valid_i = 1'b1; core_res_i = r;
    tick();
    core_valid_i = 1'b0; core_res_i = 16'h0000;
    chk({tag, "_valid_round"}, 32'(valid_o), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_result"}, 32'(result_o), 32'(exp_res));
    chk_inexact({tag, "_inexact"}, exp_inex);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy_o), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; special_i = 1'b0; core_valid_i = 1'b0; ready_i = 1'b0;
    special_res_i = 16'h0000; core_res_i = 16'h0000; exp_res_i = 8'h00;
    tick(); tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk_inexact("rst_inexact", 1'b0);
    rst = 1'b1;
    tick();

    // core_valid_i while idle is ignored
    core_valid_i = 1'b1; core_res_i = 16'hFFFF;
    tick();
    core_valid_i = 1'b0;
    chk("idle_core_busy", 32'(busy_o), 32'd0);
    chk("idle_core_valid", 32'(valid_o), 32'd0);

    run_norm("sqrt4",    8'd128, 16'h8000, 16'h4000, 1'b0);
    run_norm("sqrt2",    8'd127, 16'hB505, 16'h3FB5, 1'b1);
    run_norm("carry",    8'd127, 16'hFF80, 16'h4000, 1'b1);
    run_norm("tie_even", 8'd127, 16'h8080, 16'h3F80, 1'b1);
    run_norm("tie_odd",  8'd127, 16'h8180, 16'h3F82, 1'b1);
    run_norm("round_up", 8'd127, 16'h81C0, 16'h3F82, 1'b1);
    run_norm("norm_sh",  8'd128, 16'h6000, 16'h3FC0, 1'b0);

    // Special bypass with backpressure; a start during HOLD must be ignored
    start_i = 1'b1; special_i = 1'b1; special_res_i = 16'h7FC0;
    tick();
    special_res_i = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      chk("spec_valid", 32'(valid_o), 32'd1);
      chk("spec_result", 32'(result_o), 32'h7FC0);
      chk("spec_busy", 32'(busy_o), 32'd1);
      chk_inexact("spec_inexact", 1'b0);
      tick();
    end
    start_i = 1'b0; special_i = 1'b0;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("spec_valid_drop", 32'(valid_o), 32'd0);
    chk("spec_busy_drop", 32'(busy_o), 32'd0);
    chk("spec_result_keep", 32'(result_o), 32'h7FC0);
    tick();

    // Reset during WAIT_CORE, then a late core result
    start_i = 1'b1; exp_res_i = 8'd128;
    tick();
    start_i = 1'b0;
    chk("mid_busy", 32'(busy_o), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_result", 32'(result_o), 32'd0);
    core_valid_i = 1'b1; core_res_i = 16'h8000;
    tick();
    core_valid_i = 1'b0;
    tick(); tick();
    chk("late_core_valid", 32'(valid_o), 32'd0);
    chk("late_core_busy", 32'(busy_o), 32'd0);
    chk("late_core_result", 32'(result_o), 32'd0);

    // Normal operation still works after the abort
    run_norm("post_rst", 8'd128, 16'h8000, 16'h4000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
